// File: rtl/dmem_pkg.sv
// Shared types and defaults for the wait-state data-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

  // Width of one storage word and of the address/data buses.
  localparam int unsigned DMEM_WORD_W      = 32;
  // Default number of storage words.
  localparam int unsigned DMEM_DEPTH_WORDS = 64;
  // Default number of wait states inserted before each response.
  localparam int unsigned DMEM_WAIT_CYCLES = 2;

  // Responder FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A request is rejected when it is not word aligned or its word index
  // falls beyond the end of storage.
  function automatic logic dmem_addr_err(input logic [DMEM_WORD_W-1:0] addr,
                                         input int unsigned depth_words);
    logic [DMEM_WORD_W-1:0] word_idx;
    word_idx      = {2'b00, addr[DMEM_WORD_W-1:2]};
    dmem_addr_err = (addr[1:0] != 2'b00) || (word_idx >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between an initiator and the data-memory responder.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
interface dmem_if;
  import dmem_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [DMEM_WORD_W-1:0] req_addr;
  logic [DMEM_WORD_W-1:0] req_wdata;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [DMEM_WORD_W-1:0] resp_rdata;
  logic                   resp_err;

  // Initiator side.
  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  // Responder side.
  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage with one synchronous write port and one combinational read port.
// Latency: write lands on the clock edge; read data follows the read index in the same cycle.
// Backpressure: none; the owner gates the write enable.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [DMEM_WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]          i_raddr,
  output logic [DMEM_WORD_W-1:0] o_rdata
);

  // Not reset, so a preloaded image survives a reset of the responder.
  logic [DMEM_WORD_W-1:0] memory [DEPTH_WORDS];

  // Full-word write on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (i_we) begin
      memory[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = memory[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, inserts WAIT_CYCLES wait states, then responds.
// Latency: resp_valid rises WAIT_CYCLES+1 edges after the accepting edge (accepting edge included).
// Backpressure: response held stable until resp_ready; req_ready is high only while idle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  s_bus
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0]  CNT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  // FSM and request capture.
  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic                   r_we;
  logic [DMEM_WORD_W-1:0] r_addr;
  logic [DMEM_WORD_W-1:0] r_wdata;

  // Registered response.
  logic [DMEM_WORD_W-1:0] r_rdata;
  logic                   r_err;

  // Effective request: the live bus while idle (needed when there are no
  // wait states and the response is formed on the accepting edge itself),
  // the captured copy afterwards so later bus activity cannot leak in.
  logic                   w_idle;
  logic                   w_accept;
  logic                   w_we;
  logic [DMEM_WORD_W-1:0] w_addr;
  logic [DMEM_WORD_W-1:0] w_wdata;
  logic                   w_err;
  logic [AW-1:0]          w_idx;
  logic                   w_go_resp;
  logic                   w_mem_we;
  logic [DMEM_WORD_W-1:0] w_mem_rdata;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && s_bus.req_valid;

  assign w_we    = w_idle ? s_bus.req_we    : r_we;
  assign w_addr  = w_idle ? s_bus.req_addr  : r_addr;
  assign w_wdata = w_idle ? s_bus.req_wdata : r_wdata;

  assign w_err = dmem_addr_err(w_addr, DEPTH_WORDS);
  assign w_idx = w_addr[AW+1:2];

  // The edge that enters RESP is the one that commits a store and samples a load.
  assign w_go_resp = (NO_WAIT && w_accept) ||
                     ((r_state == ST_WAIT) && (r_cnt == 4'd0));

  // Errored requests never touch storage.
  assign w_mem_we = w_go_resp && w_we && !w_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_idx),
    .i_wdata (w_wdata),
    .i_raddr (w_idx),
    .o_rdata (w_mem_rdata)
  );

  // State sequencing, wait counter and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we    <= s_bus.req_we;
            r_addr  <= s_bus.req_addr;
            r_wdata <= s_bus.req_wdata;
            if (NO_WAIT) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (s_bus.resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Response payload is formed once on entry to RESP and then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_go_resp) begin
      r_err   <= w_err;
      r_rdata <= (w_err || w_we) ? '0 : w_mem_rdata;
    end
  end

  // req_ready depends only on state, so there is no path from req_valid.
  assign s_bus.req_ready  = w_idle;
  assign s_bus.resp_valid = (r_state == ST_RESP);
  assign s_bus.resp_rdata = r_rdata;
  assign s_bus.resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: exercises response stalls, ignored inputs and resets mid-transaction.
module tb_dmem_responder;

  localparam int W = 2;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  dmem_if bus ();
  dmem_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_bus (bus.slave)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .s_bus (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance. While the request
  // is in flight the request bus carries a conflicting store and resp_ready
  // is held high; both must be ignored.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd,
                     input logic exp_err, input int hold);
    chk1({tag, ".rdy_idle"}, bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    tick();
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h0000_0050;
    bus.req_wdata  = 32'hBADC_0FFE;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < W; k++) begin
      chk1({tag, ".wait_vld"}, bus.resp_valid, 1'b0);
      chk1({tag, ".wait_rdy"}, bus.req_ready, 1'b0);
      tick();
    end
    bus.resp_ready = 1'b0;
    chk1({tag, ".vld"}, bus.resp_valid, 1'b1);
    chk32({tag, ".rdata"}, bus.resp_rdata, exp_rd);
    chk1({tag, ".err"}, bus.resp_err, exp_err);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk1({tag, ".hold_vld"}, bus.resp_valid, 1'b1);
      chk32({tag, ".hold_rdata"}, bus.resp_rdata, exp_rd);
      chk1({tag, ".hold_err"}, bus.resp_err, exp_err);
      chk1({tag, ".hold_rdy"}, bus.req_ready, 1'b0);
    end
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk1({tag, ".done_vld"}, bus.resp_valid, 1'b0);
    chk1({tag, ".done_rdy"}, bus.req_ready, 1'b1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    bus0.req_valid  = 1'b0;
    bus0.req_we     = 1'b0;
    bus0.req_addr   = '0;
    bus0.req_wdata  = '0;
    bus0.resp_ready = 1'b0;

    tick();
    dut.u_array.memory[0]  = 32'h0BAD_0000;
    dut.u_array.memory[16] = 32'hDEAD_BEEF;
    dut.u_array.memory[17] = 32'h1717_1717;
    dut.u_array.memory[18] = 32'h1818_1818;
    dut.u_array.memory[19] = 32'h1919_1919;
    dut.u_array.memory[20] = 32'h2020_2020;
    dut.u_array.memory[63] = 32'h6363_6363;
    dut0.u_array.memory[1] = 32'h1111_0001;
    dut0.u_array.memory[2] = 32'h2222_0002;
    tick();

    // Reset state.
    chk1("rst.vld", bus.resp_valid, 1'b0);
    chk32("rst.rdata", bus.resp_rdata, 32'h0);
    chk1("rst.err", bus.resp_err, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("rst.rdy_after", bus.req_ready, 1'b1);

    // Load at 0x40 with a five-cycle response stall.
    txn("ld40", 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);
    chk32("ld40.mem20_untouched", dut.u_array.memory[20], 32'h2020_2020);

    // Store then load back at 0x44.
    txn("st44", 1'b1, 32'h0000_0044, 32'h1234_5678, 32'h0, 1'b0, 0);
    chk32("st44.mem17", dut.u_array.memory[17], 32'h1234_5678);
    txn("ld44", 1'b0, 32'h0000_0044, 32'h0, 32'h1234_5678, 1'b0, 1);

    // Misaligned load and out-of-range store.
    txn("ld42", 1'b0, 32'h0000_0042, 32'h0, 32'h0, 1'b1, 0);
    txn("st100", 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, 1'b1, 0);
    chk32("st100.mem0_alias", dut.u_array.memory[0], 32'h0BAD_0000);

    // Last valid word.
    txn("ldfc", 1'b0, 32'h0000_00FC, 32'h0, 32'h6363_6363, 1'b0, 0);

    // Reset pulsed during WAIT aborts a store to 0x48.
    chk1("rstw.rdy0", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h0000_0048;
    bus.req_wdata = 32'h7777_7777;
    tick();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    chk1("rstw.in_wait_rdy", bus.req_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("rstw.async_vld", bus.resp_valid, 1'b0);
    chk1("rstw.async_rdy", bus.req_ready, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1("rstw.no_vld", bus.resp_valid, 1'b0);
    end
    chk32("rstw.mem18", dut.u_array.memory[18], 32'h1818_1818);
    chk1("rstw.rdy_after", bus.req_ready, 1'b1);

    // Reset pulsed during RESP keeps the committed store to 0x4C.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h0000_004C;
    bus.req_wdata = 32'h4C4C_4C4C;
    tick();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    tick();
    tick();
    chk1("rstr.vld", bus.resp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rstr.async_vld", bus.resp_valid, 1'b0);
    chk32("rstr.async_rdata", bus.resp_rdata, 32'h0);
    rst_n = 1'b1;
    tick();
    chk32("rstr.mem19", dut.u_array.memory[19], 32'h4C4C_4C4C);
    chk1("rstr.rdy_after", bus.req_ready, 1'b1);
    chk1("rstr.no_vld", bus.resp_valid, 1'b0);

    // Zero wait states: response in the cycle after the accepting edge.
    chk1("w0.rdy0", bus0.req_ready, 1'b1);
    bus0.req_valid = 1'b1;
    bus0.req_addr  = 32'h0000_0004;
    tick();
    bus0.req_valid = 1'b0;
    bus0.req_addr  = 32'h0000_0008;
    chk1("w0.ld_vld", bus0.resp_valid, 1'b1);
    chk32("w0.ld_rdata", bus0.resp_rdata, 32'h1111_0001);
    chk1("w0.ld_err", bus0.resp_err, 1'b0);
    chk1("w0.ld_rdy", bus0.req_ready, 1'b0);
    bus0.resp_ready = 1'b1;
    tick();
    bus0.resp_ready = 1'b0;
    chk1("w0.ld_done", bus0.resp_valid, 1'b0);

    bus0.req_valid = 1'b1;
    bus0.req_we    = 1'b1;
    bus0.req_addr  = 32'h0000_0008;
    bus0.req_wdata = 32'hABCD_0008;
    tick();
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    chk1("w0.st_vld", bus0.resp_valid, 1'b1);
    chk32("w0.st_rdata", bus0.resp_rdata, 32'h0);
    chk32("w0.st_mem2", dut0.u_array.memory[2], 32'hABCD_0008);
    bus0.resp_ready = 1'b1;
    tick();
    bus0.resp_ready = 1'b0;

    bus0.req_valid = 1'b1;
    bus0.req_addr  = 32'h0000_0008;
    tick();
    bus0.req_valid = 1'b0;
    chk32("w0.ld2_rdata", bus0.resp_rdata, 32'hABCD_0008);
    bus0.resp_ready = 1'b1;
    tick();
    bus0.resp_ready = 1'b0;
    chk1("w0.ld2_rdy", bus0.req_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
